pipeline_output_checker: RTL and testbench
==========================================

Name: pipeline_output_checker

Overview:
- Consumer-side end of the dual-pipeline producer/consumer path.
- Samples the output words of pipeline 1 and pipeline 2 and checks each against the producer's known 8-step walking pattern:
  - lane 1 expects 32'h10000 << k
  - lane 2 expects 32'h10000 >> k
  - k = 0..7, wrapping.
- Per-lane lock/track state machines, per-lane flush requests, saturating error counters and a sticky tamper alarm. Used to detect corrupted or trojaned pipeline stages.

Parameters:
- CNT_W, 8, width of each per-lane error counter (saturating).
- ERR_THRESH, 4, combined error total (err_count_1 + err_count_2) at which alarm sets; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- pipeline1_outputs  input  32  lane 1 data word from pipeline 1
- pipeline2_outputs  input  32  lane 2 data word from pipeline 2
- out_valid  input  2  bit0 = lane 1 word valid this cycle, bit1 = lane 2 word valid this cycle
- flush_1  output  1  flush request to pipeline 1
- flush_2  output  1  flush request to pipeline 2
- locked  output  2  bit0/bit1 = lane 1/lane 2 in TRACK state
- err_count_1  output  CNT_W  lane 1 mismatch count, saturating
- err_count_2  output  CNT_W  lane 2 mismatch count, saturating
- alarm  output  1  sticky tamper alarm

Behaviour:
- All outputs registered. When reset is sampled high at a clk edge, after that edge:
  - flush_1 = flush_2 = alarm = 0
  - locked = 2'b00
  - err counts = 0
  - both lanes in SYNC with idx = 0
- Reset overrides all activity, including mid-stream and with alarm set.

Per-lane FSM (lanes identical except for the expected-pattern function):
- exp1(idx) = 32'h10000 << idx; exp2(idx) = 32'h10000 >> idx. idx is 3 bits.
- A word is consumed only in a cycle where its valid bit is 1. Cycles with valid = 0 change nothing in that lane.
- SYNC:
  - Consumed word == 32'h10000 → TRACK, idx <= 1.
  - Any other consumed word → discarded; no error, no flush.
  - locked bit = 0.
- TRACK:
  - Consumed word == exp(idx) → idx <= idx+1 mod 8; 7 wraps to 0, so 32'h800000 / 32'h200 is followed by 32'h10000.
  - Mismatch → err_count += 1 (saturating at 2^CNT_W-1); flush pulses high for exactly the next cycle; lane → SYNC, idx <= 0.
  - locked bit = 1.
- Flush and locked both change on the edge that samples the word (1-cycle latency).

Simultaneous events:
- Mismatches on both lanes in the same cycle:
  - both counters increment;
  - both flushes pulse;
  - the combined total rises by 2 for the alarm compare.
- A lane is never affected by the other lane's data or valid bit, except via alarm.

Alarm:
- Sets on the edge after the post-increment sum err_count_1 + err_count_2 (computed CNT_W+1 bits wide, no overflow) reaches ≥ ERR_THRESH.
- Sticky until reset.
- While alarm = 1:
  - flush_1 and flush_2 are held continuously high;
  - counters keep counting (still saturating);
  - the lane FSMs keep running.
- A mismatch that triggers alarm gives the same cycle timing for flush pulse and alarm set.

Saturation: a counter at its maximum stays at maximum; a mismatch still flushes and resyncs.

Test Plan:
1. Reset, then lane 1 fed 32'h10000, 20000, 40000, …, 800000, 10000 with valid every cycle → locked[0] = 1 from the cycle after the first word; err_count_1 = 0; flush_1 never high across 2 full wraps.
2. Lane 2 in TRACK expecting 32'h4000 (idx 2) receives 32'h4001 → flush_2 high for exactly 1 cycle on the next cycle; err_count_2 = 1; locked[1] = 0. Then 32'h8000 (discarded, no error), then 32'h10000 → locked[1] = 1.
3. Both lanes locked, corrupt word on both in the same cycle with ERR_THRESH = 4 → both counts = 1, both flushes pulse. Repeat once → counts = 2/2, alarm = 1 on the same edge; flush_1 = flush_2 stay high on every later cycle.
4. Valid gaps: lane 1 pattern 10000, (valid = 0 with junk data 3 cycles), 20000 → no error, idx advances once per valid word only.
5. CNT_W = 2, ERR_THRESH = 3, 5 mismatches on lane 1 only → err_count_1 saturates at 3; alarm sets after the 3rd mismatch.
6. Reset asserted for 1 cycle mid-stream with alarm = 1 and lanes locked → all outputs 0 after that edge; the lane needs a fresh 32'h10000 to relock.

Source files
------------

// File: rtl/pipeline_output_checker.sv
// Consumer-side checker for the dual-pipeline walking-pattern path: per-lane lock/track,
// flush requests, saturating error counters and a sticky tamper alarm.

module pipeline_lane_tracker #(
  parameter bit SHIFT_LEFT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        valid,
  output logic        locked,
  output logic        mismatch
);

  typedef enum logic [0:0] {SYNC, TRACK} lane_state_t;

  localparam logic [31:0] SEED = 32'h0001_0000;

  lane_state_t state, state_next;
  logic [2:0]  idx, idx_next;
  logic [31:0] expected;

  // Lane 1 walks the seed bit upwards, lane 2 walks it downwards.
  assign expected = SHIFT_LEFT ? (SEED << idx) : (SEED >> idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SYNC;
      idx   <= 3'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    mismatch   = 1'b0;
    if (valid) begin
      unique case (state)
        SYNC: begin
          if (data == SEED) begin
            state_next = TRACK;
            idx_next   = 3'd1;
          end
        end
        TRACK: begin
          if (data == expected) begin
            idx_next = idx + 3'd1;
          end else begin
            mismatch   = 1'b1;
            state_next = SYNC;
            idx_next   = 3'd0;
          end
        end
        default: begin
          state_next = SYNC;
          idx_next   = 3'd0;
        end
      endcase
    end
  end

  assign locked = (state == TRACK);

endmodule

module pipeline_output_checker #(
  parameter int CNT_W      = 8,
  parameter int ERR_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pipeline1_outputs,
  input  logic [31:0]      pipeline2_outputs,
  input  logic [1:0]       out_valid,
  output logic             flush_1,
  output logic             flush_2,
  output logic [1:0]       locked,
  output logic [CNT_W-1:0] err_count_1,
  output logic [CNT_W-1:0] err_count_2,
  output logic             alarm
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   THRESH  = (CNT_W+1)'(ERR_THRESH);

  logic             mismatch_1, mismatch_2;
  logic             locked_1, locked_2;
  logic [CNT_W-1:0] cnt_1_next, cnt_2_next;
  logic [CNT_W:0]   err_total_next;
  logic             alarm_next;

  pipeline_lane_tracker #(.SHIFT_LEFT(1'b1)) lane_1 (
    .clk      (clk),
    .reset    (reset),
    .data     (pipeline1_outputs),
    .valid    (out_valid[0]),
    .locked   (locked_1),
    .mismatch (mismatch_1)
  );

  pipeline_lane_tracker #(.SHIFT_LEFT(1'b0)) lane_2 (
    .clk      (clk),
    .reset    (reset),
    .data     (pipeline2_outputs),
    .valid    (out_valid[1]),
    .locked   (locked_2),
    .mismatch (mismatch_2)
  );

  assign locked = {locked_2, locked_1};

  // Alarm compares the post-increment total, one bit wider so it never wraps.
  always_comb begin
    cnt_1_next = err_count_1;
    cnt_2_next = err_count_2;
    if (mismatch_1 && (err_count_1 != CNT_MAX)) cnt_1_next = err_count_1 + CNT_W'(1);
    if (mismatch_2 && (err_count_2 != CNT_MAX)) cnt_2_next = err_count_2 + CNT_W'(1);
    err_total_next = {1'b0, cnt_1_next} + {1'b0, cnt_2_next};
    alarm_next     = alarm || (err_total_next >= THRESH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_1     <= 1'b0;
      flush_2     <= 1'b0;
      err_count_1 <= '0;
      err_count_2 <= '0;
      alarm       <= 1'b0;
    end else begin
      flush_1     <= mismatch_1 || alarm_next;
      flush_2     <= mismatch_2 || alarm_next;
      err_count_1 <= cnt_1_next;
      err_count_2 <= cnt_2_next;
      alarm       <= alarm_next;
    end
  end

endmodule

// File: tb/tb_pipeline_output_checker.sv
// Directed bench for pipeline_output_checker: a reference model fills a scoreboard queue
// as each step is driven, and every DUT output is compared after the sampling edge.

module tb_pipeline_output_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic [1:0]  a_valid, b_valid;

  logic       a_flush_1, a_flush_2, a_alarm;
  logic [1:0] a_locked;
  logic [7:0] a_err_1, a_err_2;
  logic       b_flush_1, b_flush_2, b_alarm;
  logic [1:0] b_locked;
  logic [1:0] b_err_1, b_err_2;

  pipeline_output_checker #(.CNT_W(8), .ERR_THRESH(4)) dut_a (
    .clk               (clk),
    .reset             (reset),
    .pipeline1_outputs (a_d1),
    .pipeline2_outputs (a_d2),
    .out_valid         (a_valid),
    .flush_1           (a_flush_1),
    .flush_2           (a_flush_2),
    .locked            (a_locked),
    .err_count_1       (a_err_1),
    .err_count_2       (a_err_2),
    .alarm             (a_alarm)
  );

  pipeline_output_checker #(.CNT_W(2), .ERR_THRESH(3)) dut_b (
    .clk               (clk),
    .reset             (reset),
    .pipeline1_outputs (b_d1),
    .pipeline2_outputs (b_d2),
    .out_valid         (b_valid),
    .flush_1           (b_flush_1),
    .flush_2           (b_flush_2),
    .locked            (b_locked),
    .err_count_1       (b_err_1),
    .err_count_2       (b_err_2),
    .alarm             (b_alarm)
  );

  typedef struct packed {
    logic [1:0]  track;
    logic [2:0]  idx1;
    logic [2:0]  idx2;
    logic [31:0] cnt1;
    logic [31:0] cnt2;
    logic        alarm;
    logic [1:0]  flush;
  } model_t;

  typedef struct packed {
    model_t a;
    model_t b;
  } expect_t;

  model_t  ma, mb;
  expect_t sb_q[$];
  int      checks = 0;
  int      errors = 0;

  function automatic logic [31:0] pattern(input int lane, input logic [2:0] k);
    logic [31:0] seed = 32'h0001_0000;
    return (lane == 1) ? (seed << k) : (seed >> k);
  endfunction

  function automatic model_t model_step(input model_t m, input int cmax, input int thr,
                                        input logic [1:0] v, input logic [31:0] d1,
                                        input logic [31:0] d2);
    model_t     n = m;
    logic [1:0] bad = 2'b00;
    if (v[0]) begin
      if (!m.track[0]) begin
        if (d1 == 32'h0001_0000) begin n.track[0] = 1'b1; n.idx1 = 3'd1; end
      end else if (d1 == pattern(1, m.idx1)) begin
        n.idx1 = m.idx1 + 3'd1;
      end else begin
        bad[0] = 1'b1; n.track[0] = 1'b0; n.idx1 = 3'd0;
      end
    end
    if (v[1]) begin
      if (!m.track[1]) begin
        if (d2 == 32'h0001_0000) begin n.track[1] = 1'b1; n.idx2 = 3'd1; end
      end else if (d2 == pattern(2, m.idx2)) begin
        n.idx2 = m.idx2 + 3'd1;
      end else begin
        bad[1] = 1'b1; n.track[1] = 1'b0; n.idx2 = 3'd0;
      end
    end
    if (bad[0] && (n.cnt1 < 32'(cmax))) n.cnt1 = n.cnt1 + 32'd1;
    if (bad[1] && (n.cnt2 < 32'(cmax))) n.cnt2 = n.cnt2 + 32'd1;
    if ((n.cnt1 + n.cnt2) >= 32'(thr)) n.alarm = 1'b1;
    n.flush = bad | {2{n.alarm}};
    return n;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst,
                                input logic [1:0] va, input logic [31:0] a1, input logic [31:0] a2,
                                input logic [1:0] vb, input logic [31:0] b1, input logic [31:0] b2);
    expect_t e;
    reset   = rst;
    a_valid = va; a_d1 = a1; a_d2 = a2;
    b_valid = vb; b_d1 = b1; b_d2 = b2;
    if (rst) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = model_step(ma, 255, 4, va, a1, a2);
      mb = model_step(mb, 3, 3, vb, b1, b2);
    end
    e.a = ma;
    e.b = mb;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_output("a_locked",  {30'd0, a_locked},  {30'd0, e.a.track});
    check_output("a_flush_1", {31'd0, a_flush_1}, {31'd0, e.a.flush[0]});
    check_output("a_flush_2", {31'd0, a_flush_2}, {31'd0, e.a.flush[1]});
    check_output("a_err_1",   {24'd0, a_err_1},   e.a.cnt1);
    check_output("a_err_2",   {24'd0, a_err_2},   e.a.cnt2);
    check_output("a_alarm",   {31'd0, a_alarm},   {31'd0, e.a.alarm});
    check_output("b_locked",  {30'd0, b_locked},  {30'd0, e.b.track});
    check_output("b_flush_1", {31'd0, b_flush_1}, {31'd0, e.b.flush[0]});
    check_output("b_flush_2", {31'd0, b_flush_2}, {31'd0, e.b.flush[1]});
    check_output("b_err_1",   {30'd0, b_err_1},   e.b.cnt1);
    check_output("b_err_2",   {30'd0, b_err_2},   e.b.cnt2);
    check_output("b_alarm",   {31'd0, b_alarm},   {31'd0, e.b.alarm});
  endtask

  task automatic step_a(input logic [1:0] v, input logic [31:0] d1, input logic [31:0] d2);
    apply_stimulus(1'b0, v, d1, d2, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic step_b(input logic [1:0] v, input logic [31:0] d1, input logic [31:0] d2);
    apply_stimulus(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, v, d1, d2);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 2'b11, 32'h0001_0000, 32'h0001_0000, 2'b11, 32'h0001_0000, 32'h0001_0000);
  endtask

  initial begin
    ma = '0;
    mb = '0;
    do_reset();
    do_reset();

    $display("[TB] lane 1 walking pattern, two full wraps");
    for (int i = 0; i < 17; i++) step_a(2'b01, pattern(1, 3'(i)), 32'h0);
    check_output("t1_locked0", {31'd0, a_locked[0]}, 32'd1);

    $display("[TB] lane 2 corruption and relock");
    step_a(2'b10, 32'h0, 32'h0001_0000);
    step_a(2'b10, 32'h0, 32'h0000_8000);
    step_a(2'b10, 32'h0, 32'h0000_4001);
    check_output("t2_flush_2", {31'd0, a_flush_2}, 32'd1);
    check_output("t2_err_2", {24'd0, a_err_2}, 32'd1);
    step_a(2'b00, 32'h0, 32'h0000_4000);
    check_output("t2_flush_2_end", {31'd0, a_flush_2}, 32'd0);
    step_a(2'b10, 32'h0, 32'h0000_8000);
    step_a(2'b10, 32'h0, 32'h0001_0000);
    check_output("t2_relock", {31'd0, a_locked[1]}, 32'd1);

    $display("[TB] simultaneous mismatches drive the alarm");
    do_reset();
    step_a(2'b11, 32'h0001_0000, 32'h0001_0000);
    step_a(2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step_a(2'b11, 32'h0001_0000, 32'h0001_0000);
    step_a(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    check_output("t3_alarm", {31'd0, a_alarm}, 32'd1);
    for (int i = 0; i < 3; i++) step_a(2'b00, 32'h0, 32'h0);
    check_output("t3_flush_held", {30'd0, a_flush_2, a_flush_1}, 32'd3);

    $display("[TB] reset mid-stream with alarm set");
    step_a(2'b11, 32'h0001_0000, 32'h0001_0000);
    step_a(2'b11, 32'h0002_0000, 32'h0000_8000);
    do_reset();
    step_a(2'b01, 32'h0002_0000, 32'h0);
    step_a(2'b01, 32'h0001_0000, 32'h0);
    check_output("t6_relock", {31'd0, a_locked[0]}, 32'd1);

    $display("[TB] valid gaps on lane 1");
    do_reset();
    step_a(2'b01, 32'h0001_0000, 32'h0);
    for (int i = 0; i < 3; i++) step_a(2'b00, 32'h0002_0000, 32'h0002_0000);
    step_a(2'b01, 32'h0002_0000, 32'h0);
    step_a(2'b01, 32'h0004_0000, 32'h0);
    check_output("t4_err_1", {24'd0, a_err_1}, 32'd0);

    $display("[TB] narrow counter saturation");
    for (int i = 0; i < 5; i++) begin
      step_b(2'b01, 32'h0001_0000, 32'h0);
      step_b(2'b01, 32'h1234_5678, 32'h0);
    end
    check_output("t5_sat", {30'd0, b_err_1}, 32'd3);
    check_output("t5_alarm", {31'd0, b_alarm}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
